// File: rtl/imem_if.sv
// imem_if: req/ack handshake between the fetch stage and the instruction memory.
//   req   - fetch request (master -> slave)
//   addr  - fetch address, stable while req=1 and ack=0 (master -> slave)
//   ack   - rdata valid this cycle, completes the request (slave -> master)
//   rdata - fetched instruction word (slave -> master)
interface imem_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage holding the PC, fetching over imem_if and owning the IF/ID register.
//   clk, rst_n   - clock and asynchronous active-low reset
//   stall        - hold PC and IF/ID
//   redirect_en  - branch/jump taken, load redirect_pc (word aligned)
//   redirect_pc  - branch/jump target
//   imem         - instruction memory master port (req/addr/ack/rdata)
//   instruc      - IF/ID instruction word
//   pc_plus4     - IF/ID address of that instruction plus 4
//   if_valid     - IF/ID holds a real instruction
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    imem_if.master      imem,
    output logic [31:0] instruc,
    output logic [31:0] pc_plus4,
    output logic        if_valid
);
    typedef enum logic [1:0] {IDLE, FETCH, SQUASH} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instruc_q, instruc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic [31:0] red_pc, pc_inc;

    // Masking keeps every bit of redirect_pc in use while forcing word alignment.
    assign red_pc = redirect_pc & ~32'h3;
    assign pc_inc = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        instruc_d  = instruc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: begin
                pc_d    = redirect_en ? red_pc : pc_q;
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = pc_d;
            end
            FETCH: begin
                if (redirect_en) begin
                    // An unacked request must drain in SQUASH before the new pc is requested.
                    pc_d      = red_pc;
                    instruc_d = NOP_WORD;
                    valid_d   = 1'b0;
                    state_d   = imem.ack ? FETCH : SQUASH;
                    addr_d    = imem.ack ? red_pc : addr_q;
                end else if (!stall) begin
                    if (imem.ack) begin
                        instruc_d  = imem.rdata;
                        pc_plus4_d = pc_inc;
                        valid_d    = 1'b1;
                        pc_d       = pc_inc;
                        addr_d     = pc_inc;
                    end else begin
                        instruc_d = NOP_WORD;
                        valid_d   = 1'b0;
                    end
                end
                // On stall an acked word is dropped; req stays high, so addr=pc is re-requested.
            end
            SQUASH: begin
                pc_d      = redirect_en ? red_pc : pc_q;
                instruc_d = NOP_WORD;
                valid_d   = 1'b0;
                state_d   = imem.ack ? FETCH : SQUASH;
                addr_d    = imem.ack ? pc_d : addr_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            instruc_q  <= NOP_WORD;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            instruc_q  <= instruc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign imem.req  = req_q;
    assign imem.addr = addr_q;
    assign instruc   = instruc_q;
    assign pc_plus4  = pc_plus4_q;
    assign if_valid  = valid_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed stimulus for instruction_fetch with immediate-assertion checks.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instruc, pc_plus4;
    logic        if_valid;
    int          total = 0;
    int          bad = 0;

    imem_if imem ();

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .imem(imem), .instruc(instruc),
        .pc_plus4(pc_plus4), .if_valid(if_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4, input logic v);
        chk({tag, "_instruc"}, instruc, ins);
        chk({tag, "_pc_plus4"}, pc_plus4, p4);
        chk({tag, "_valid"}, {31'h0, if_valid}, {31'h0, v});
    endtask

    task automatic bus(input string tag, input logic r, input logic [31:0] a);
        chk({tag, "_req"}, {31'h0, imem.req}, {31'h0, r});
        chk({tag, "_addr"}, imem.addr, a);
    endtask

    initial begin
        imem.ack = 1'b0;
        imem.rdata = 32'h0;
        tick();
        tick();
        ifid("reset", 32'h0, 32'h0, 1'b0);
        bus("reset", 1'b0, 32'h0);
        rst_n = 1'b1;
        tick();
        bus("req_rise", 1'b1, 32'h0);
        // Test 1: zero-wait streaming
        imem.ack = 1'b1; imem.rdata = 32'h20010005;
        tick();
        ifid("t1_w0", 32'h20010005, 32'h4, 1'b1);
        bus("t1_w0", 1'b1, 32'h4);
        imem.rdata = 32'h20020007;
        tick();
        ifid("t1_w1", 32'h20020007, 32'h8, 1'b1);
        bus("t1_w1", 1'b1, 32'h8);
        // Test 2: two wait cycles at 0x8
        imem.ack = 1'b0; imem.rdata = 32'hDEADBEEF;
        tick();
        ifid("t2_wait0", 32'h0, 32'h8, 1'b0);
        bus("t2_wait0", 1'b1, 32'h8);
        tick();
        ifid("t2_wait1", 32'h0, 32'h8, 1'b0);
        bus("t2_wait1", 1'b1, 32'h8);
        imem.ack = 1'b1; imem.rdata = 32'h2003000B;
        tick();
        ifid("t2_cap", 32'h2003000B, 32'hC, 1'b1);
        bus("t2_cap", 1'b1, 32'hC);
        // Test 3: three stall cycles with acked words discarded
        stall = 1'b1; imem.rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            tick();
            ifid("t3_stall", 32'h2003000B, 32'hC, 1'b1);
            bus("t3_stall", 1'b1, 32'hC);
        end
        stall = 1'b0; imem.rdata = 32'h2004000C;
        tick();
        ifid("t3_resume", 32'h2004000C, 32'h10, 1'b1);
        bus("t3_resume", 1'b1, 32'h10);
        // Test 4: redirect to 0x40 while 0x10 is pending
        imem.ack = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h40;
        tick();
        ifid("t4_redir", 32'h0, 32'h10, 1'b0);
        bus("t4_redir", 1'b1, 32'h10);
        redirect_en = 1'b0;
        tick();
        ifid("t4_squash", 32'h0, 32'h10, 1'b0);
        bus("t4_squash", 1'b1, 32'h10);
        imem.ack = 1'b1; imem.rdata = 32'hBAD00010;
        tick();
        ifid("t4_drain", 32'h0, 32'h10, 1'b0);
        bus("t4_drain", 1'b1, 32'h40);
        imem.rdata = 32'h20050040;
        tick();
        ifid("t4_target", 32'h20050040, 32'h44, 1'b1);
        bus("t4_target", 1'b1, 32'h44);
        // Test 5: stall + redirect on an ack, unaligned target
        stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h103; imem.rdata = 32'hBAD00044;
        tick();
        ifid("t5_flush", 32'h0, 32'h44, 1'b0);
        bus("t5_flush", 1'b1, 32'h100);
        stall = 1'b0; redirect_en = 1'b0; imem.rdata = 32'h20060100;
        tick();
        ifid("t5_target", 32'h20060100, 32'h104, 1'b1);
        bus("t5_target", 1'b1, 32'h104);
        // pc+4 wraps at the top of the address space
        redirect_en = 1'b1; redirect_pc = 32'hFFFFFFFF;
        tick();
        bus("wrap_redir", 1'b1, 32'hFFFFFFFC);
        redirect_en = 1'b0; imem.rdata = 32'h11111111;
        tick();
        ifid("wrap", 32'h11111111, 32'h0, 1'b1);
        bus("wrap", 1'b1, 32'h0);
        // Test 6: asynchronous reset mid-request, ack held across reset
        imem.ack = 1'b0;
        tick();
        bus("t6_pending", 1'b1, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        ifid("t6_async", 32'h0, 32'h0, 1'b0);
        bus("t6_async", 1'b0, 32'h0);
        imem.ack = 1'b1; imem.rdata = 32'hBAD0FFFF;
        tick();
        bus("t6_hold", 1'b0, 32'h0);
        rst_n = 1'b1;
        tick();
        ifid("t6_idle_ack", 32'h0, 32'h0, 1'b0);
        bus("t6_idle_ack", 1'b1, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
